// File: rtl/vanilla_decode_queue.sv
// Decode buffer between fetch and the vanilla issue stage: decodes on enqueue,
// stores instruction/PC/decode/fp_decode/illegal in a flop FIFO, counts illegal ops.
module vanilla_decode_queue #(
  parameter int els_p               = 4,
  parameter int pc_width_p          = 22,
  parameter bit fp_en_p             = 1'b1,
  parameter bit amo_en_p            = 1'b1,
  parameter int illegal_cnt_width_p = 8,
  localparam int decode_width_lp    = 25,
  localparam int fp_decode_width_lp = 9,
  localparam int cnt_w_lp           = $clog2(els_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic                           v_i,
  input  logic [31:0]                    instr_i,
  input  logic [pc_width_p-1:0]          pc_i,
  output logic                           ready_o,
  output logic                           v_o,
  output logic [31:0]                    instr_o,
  output logic [pc_width_p-1:0]          pc_o,
  output logic [decode_width_lp-1:0]     decode_o,
  output logic [fp_decode_width_lp-1:0]  fp_decode_o,
  output logic                           illegal_o,
  input  logic                           yumi_i,
  output logic [cnt_w_lp-1:0]            count_o,
  output logic [illegal_cnt_width_p-1:0] illegal_count_o
);

  localparam int ptr_w_lp = $clog2(els_p);

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AMO      = 7'b0101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OP_STORE_FP = 7'b0100111;
  localparam logic [6:0] OP_OP_FP    = 7'b1010011;
  localparam logic [6:0] OP_FMADD    = 7'b1000011;
  localparam logic [6:0] OP_FMSUB    = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OP_FNMADD   = 7'b1001111;

  typedef enum logic [4:0] {
    FADD, FSUB, FMUL, FDIV, FSQRT, FSGNJ, FSGNJN, FSGNJX, FMIN, FMAX,
    FEQ, FLT, FLE, FCLASS, FCVT_W_S, FCVT_WU_S, FCVT_S_W, FCVT_S_WU,
    FMV_X_W, FMV_W_X, FMADD_OP, FMSUB_OP, FNMSUB_OP, FNMADD_OP
  } fpu_op_e;

  // write_rd/read_rs1/read_rs2 occupy the three most significant bits.
  typedef struct packed {
    logic write_rd;
    logic read_rs1;
    logic read_rs2;
    logic write_frd;
    logic read_frs1;
    logic read_frs2;
    logic read_frs3;
    logic is_load_op;
    logic is_store_op;
    logic is_byte_op;
    logic is_hex_op;
    logic is_load_unsigned;
    logic is_branch_op;
    logic is_jal_op;
    logic is_jalr_op;
    logic is_md_op;
    logic is_fp_op;
    logic is_amo_op;
    logic is_lr_op;
    logic is_lr_aq_op;
    logic is_fence_op;
    logic is_fence_i_op;
    logic is_csr_op;
    logic is_mret_op;
    logic unsupported;
  } decode_s;

  typedef struct packed {
    fpu_op_e fpu_op;
    logic    is_fpu_float_op;
    logic    is_fpu_int_op;
    logic    is_fdiv_op;
    logic    is_fsqrt_op;
  } fp_decode_s;

  typedef struct packed {
    logic [31:0]           instr;
    logic [pc_width_p-1:0] pc;
    decode_s               dec;
    fp_decode_s            fpd;
    logic                  illegal;
  } entry_s;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_funct5;
  logic [4:0] w_rs2;
  decode_s    w_dec;
  fp_decode_s w_fpd;
  logic       w_known_op;
  logic       w_illegal;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];
  assign w_funct5 = instr_i[31:27];
  assign w_rs2    = instr_i[24:20];

  always_comb begin
    w_dec = '0;
    w_fpd = '0;
    case (w_opcode)
      OP_LUI, OP_AUIPC: w_dec.write_rd = 1'b1;
      OP_JAL: begin
        w_dec.write_rd  = 1'b1;
        w_dec.is_jal_op = 1'b1;
      end
      OP_JALR: begin
        w_dec.write_rd    = 1'b1;
        w_dec.read_rs1    = 1'b1;
        w_dec.is_jalr_op  = 1'b1;
        w_dec.unsupported = (w_funct3 != 3'b000);
      end
      OP_BRANCH: begin
        w_dec.read_rs1     = 1'b1;
        w_dec.read_rs2     = 1'b1;
        w_dec.is_branch_op = 1'b1;
        w_dec.unsupported  = (w_funct3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        w_dec.write_rd         = 1'b1;
        w_dec.read_rs1         = 1'b1;
        w_dec.is_load_op       = 1'b1;
        w_dec.is_byte_op       = (w_funct3[1:0] == 2'b00);
        w_dec.is_hex_op        = (w_funct3[1:0] == 2'b01);
        w_dec.is_load_unsigned = w_funct3[2];
        w_dec.unsupported      = (w_funct3[1:0] == 2'b11) || (w_funct3 == 3'b110);
      end
      OP_STORE: begin
        w_dec.read_rs1    = 1'b1;
        w_dec.read_rs2    = 1'b1;
        w_dec.is_store_op = 1'b1;
        w_dec.is_byte_op  = (w_funct3[1:0] == 2'b00);
        w_dec.is_hex_op   = (w_funct3[1:0] == 2'b01);
        w_dec.unsupported = w_funct3[2] || (w_funct3[1:0] == 2'b11);
      end
      OP_OP_IMM: begin
        w_dec.write_rd = 1'b1;
        w_dec.read_rs1 = 1'b1;
        if (w_funct3 == 3'b001)
          w_dec.unsupported = (w_funct7 != 7'b0000000);
        else if (w_funct3 == 3'b101)
          w_dec.unsupported = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
      end
      OP_OP: begin
        w_dec.write_rd = 1'b1;
        w_dec.read_rs1 = 1'b1;
        w_dec.read_rs2 = 1'b1;
        case (w_funct7)
          7'b0000000: w_dec.unsupported = 1'b0;
          7'b0100000: w_dec.unsupported = (w_funct3 != 3'b000) && (w_funct3 != 3'b101);
          7'b0000001: begin
            // Only the low-half multiply and the divide/remainder group exist here.
            w_dec.is_md_op    = 1'b1;
            w_dec.unsupported = (w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                                (w_funct3 == 3'b011);
          end
          default: w_dec.unsupported = 1'b1;
        endcase
      end
      OP_AMO: begin
        w_dec.write_rd = 1'b1;
        w_dec.read_rs1 = 1'b1;
        if (w_funct5 == 5'b00010) begin
          w_dec.is_lr_op    = ~instr_i[26];
          w_dec.is_lr_aq_op = instr_i[26];
          w_dec.unsupported = (w_rs2 != 5'd0);
        end else begin
          w_dec.read_rs2    = 1'b1;
          w_dec.is_amo_op   = 1'b1;
          w_dec.unsupported = !(w_funct5 inside {5'b00001, 5'b00000, 5'b00100, 5'b01000,
                                                 5'b01100, 5'b10000, 5'b10100, 5'b11000,
                                                 5'b11100});
        end
        w_dec.unsupported = w_dec.unsupported || (w_funct3 != 3'b010);
      end
      OP_SYSTEM: begin
        if (w_funct3 == 3'b000) begin
          w_dec.is_mret_op  = (instr_i == 32'h30200073);
          w_dec.unsupported = (instr_i != 32'h30200073);
        end else begin
          w_dec.is_csr_op   = 1'b1;
          w_dec.write_rd    = 1'b1;
          w_dec.read_rs1    = ~w_funct3[2];
          w_dec.unsupported = (w_funct3 == 3'b100);
        end
      end
      OP_MISC_MEM: begin
        w_dec.is_fence_op   = (w_funct3 == 3'b000);
        w_dec.is_fence_i_op = (w_funct3 == 3'b001);
        w_dec.unsupported   = (w_funct3[2:1] != 2'b00);
      end
      OP_LOAD_FP: begin
        w_dec.read_rs1    = 1'b1;
        w_dec.write_frd   = 1'b1;
        w_dec.is_load_op  = 1'b1;
        w_dec.unsupported = (w_funct3 != 3'b010);
      end
      OP_STORE_FP: begin
        w_dec.read_rs1    = 1'b1;
        w_dec.read_frs2   = 1'b1;
        w_dec.is_store_op = 1'b1;
        w_dec.unsupported = (w_funct3 != 3'b010);
      end
      OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
        w_dec.is_fp_op        = 1'b1;
        w_dec.write_frd       = 1'b1;
        w_dec.read_frs1       = 1'b1;
        w_dec.read_frs2       = 1'b1;
        w_dec.read_frs3       = 1'b1;
        w_dec.unsupported     = (w_funct7[1:0] != 2'b00);
        w_fpd.is_fpu_float_op = 1'b1;
        w_fpd.fpu_op = (w_opcode == OP_FMADD)  ? FMADD_OP :
                       (w_opcode == OP_FMSUB)  ? FMSUB_OP :
                       (w_opcode == OP_FNMSUB) ? FNMSUB_OP : FNMADD_OP;
      end
      OP_OP_FP: begin
        w_dec.is_fp_op    = 1'b1;
        w_dec.unsupported = (w_funct7[1:0] != 2'b00);
        case (w_funct7[6:2])
          5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101: begin
            w_dec.write_frd       = 1'b1;
            w_dec.read_frs1       = 1'b1;
            w_dec.read_frs2       = 1'b1;
            w_fpd.is_fpu_float_op = 1'b1;
            w_fpd.is_fdiv_op      = (w_funct7[6:2] == 5'b00011);
            case (w_funct7[6:2])
              5'b00000: w_fpd.fpu_op = FADD;
              5'b00001: w_fpd.fpu_op = FSUB;
              5'b00010: w_fpd.fpu_op = FMUL;
              5'b00011: w_fpd.fpu_op = FDIV;
              5'b00100: w_fpd.fpu_op = (w_funct3 == 3'b000) ? FSGNJ :
                                       (w_funct3 == 3'b001) ? FSGNJN : FSGNJX;
              default:  w_fpd.fpu_op = (w_funct3 == 3'b000) ? FMIN : FMAX;
            endcase
            if (w_funct7[6:2] == 5'b00100)
              w_dec.unsupported = w_dec.unsupported || (w_funct3 > 3'b010);
            if (w_funct7[6:2] == 5'b00101)
              w_dec.unsupported = w_dec.unsupported || (w_funct3 > 3'b001);
          end
          5'b01011: begin
            w_dec.write_frd       = 1'b1;
            w_dec.read_frs1       = 1'b1;
            w_fpd.is_fpu_float_op = 1'b1;
            w_fpd.is_fsqrt_op     = 1'b1;
            w_fpd.fpu_op          = FSQRT;
            w_dec.unsupported     = w_dec.unsupported || (w_rs2 != 5'd0);
          end
          5'b10100: begin
            w_dec.write_rd      = 1'b1;
            w_dec.read_frs1     = 1'b1;
            w_dec.read_frs2     = 1'b1;
            w_fpd.is_fpu_int_op = 1'b1;
            w_fpd.fpu_op = (w_funct3 == 3'b000) ? FLE : (w_funct3 == 3'b001) ? FLT : FEQ;
            w_dec.unsupported   = w_dec.unsupported || (w_funct3 > 3'b010);
          end
          5'b11000: begin
            w_dec.write_rd      = 1'b1;
            w_dec.read_frs1     = 1'b1;
            w_fpd.is_fpu_int_op = 1'b1;
            w_fpd.fpu_op        = w_rs2[0] ? FCVT_WU_S : FCVT_W_S;
            w_dec.unsupported   = w_dec.unsupported || (w_rs2[4:1] != 4'd0);
          end
          5'b11100: begin
            w_dec.write_rd      = 1'b1;
            w_dec.read_frs1     = 1'b1;
            w_fpd.is_fpu_int_op = 1'b1;
            w_fpd.fpu_op        = w_funct3[0] ? FCLASS : FMV_X_W;
            w_dec.unsupported   = w_dec.unsupported || (w_funct3[2:1] != 2'b00);
          end
          5'b11010, 5'b11110: begin
            // Integer-sourced ops produce an FP result, so they retire as float ops.
            w_dec.write_frd       = 1'b1;
            w_dec.read_rs1        = 1'b1;
            w_fpd.is_fpu_float_op = 1'b1;
            if (w_funct7[6:2] == 5'b11110) begin
              w_fpd.fpu_op      = FMV_W_X;
              w_dec.unsupported = w_dec.unsupported || (w_funct3 != 3'b000);
            end else begin
              w_fpd.fpu_op      = w_rs2[0] ? FCVT_S_WU : FCVT_S_W;
              w_dec.unsupported = w_dec.unsupported || (w_rs2[4:1] != 4'd0);
            end
          end
          default: w_dec.unsupported = 1'b1;
        endcase
      end
      default: w_dec.unsupported = 1'b1;
    endcase
  end

  assign w_known_op = w_opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                       OP_LOAD, OP_STORE, OP_OP, OP_OP_IMM, OP_AMO,
                                       OP_SYSTEM, OP_MISC_MEM, OP_LOAD_FP, OP_STORE_FP,
                                       OP_OP_FP, OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD};

  assign w_illegal = w_dec.unsupported || !w_known_op ||
                     (!fp_en_p && (w_dec.is_fp_op || (w_opcode == OP_LOAD_FP) ||
                                   (w_opcode == OP_STORE_FP))) ||
                     (!amo_en_p && (w_dec.is_amo_op || w_dec.is_lr_op || w_dec.is_lr_aq_op));

  entry_s                         r_mem [els_p];
  logic [ptr_w_lp-1:0]            r_wptr;
  logic [ptr_w_lp-1:0]            r_rptr;
  logic [cnt_w_lp-1:0]            r_count;
  logic [illegal_cnt_width_p-1:0] r_illegal_cnt;
  logic                           w_full;
  logic                           w_enq;
  logic                           w_deq;
  entry_s                         w_new;
  entry_s                         w_head;

  assign w_full  = (r_count == cnt_w_lp'(els_p));
  assign ready_o = ~w_full & ~reset_i;
  assign v_o     = (r_count != '0);
  assign w_enq   = v_i & ready_o & ~flush_i;
  assign w_deq   = yumi_i & v_o & ~flush_i;

  assign w_new = '{instr: instr_i, pc: pc_i, dec: w_dec, fpd: w_fpd, illegal: w_illegal};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_illegal_cnt <= '0;
    end else if (flush_i) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + ptr_w_lp'(1);
      if (w_deq) r_rptr <= r_rptr + ptr_w_lp'(1);
      if (w_enq && !w_deq)      r_count <= r_count + cnt_w_lp'(1);
      else if (!w_enq && w_deq) r_count <= r_count - cnt_w_lp'(1);
      if (w_enq && w_illegal && (r_illegal_cnt != '1))
        r_illegal_cnt <= r_illegal_cnt + illegal_cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= w_new;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(yumi_i && !v_o));
  end

  assign w_head          = r_mem[r_rptr];
  assign instr_o         = w_head.instr;
  assign pc_o            = w_head.pc;
  assign decode_o        = w_head.dec;
  assign fp_decode_o     = w_head.fpd;
  assign illegal_o       = w_head.illegal;
  assign count_o         = r_count;
  assign illegal_count_o = r_illegal_cnt;

endmodule
